// File: rtl/rr_port_scheduler_if.sv
// rtl/rr_port_scheduler_if.sv - requester/resource handshake bundle for rr_port_scheduler
interface rr_port_scheduler_if #(
  parameter int NREQ = 8
);
  logic            ce;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic            rdy;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [3:0]      gnt_enc;
  logic            gnt_vld;
  logic            start;
  logic            tmo;
  logic [3:0]      tmo_id;
  logic            busy;

  // Requesters/resource side drives requests and completion.
  modport master (
    output ce, req, lock, rdy, done,
    input  gnt, gnt_enc, gnt_vld, start, tmo, tmo_id, busy
  );

  // Scheduler side.
  modport slave (
    input  ce, req, lock, rdy, done,
    output gnt, gnt_enc, gnt_vld, start, tmo, tmo_id, busy
  );
endinterface

// File: rtl/rr_port_scheduler.sv
// rtl/rr_port_scheduler.sv - round-robin transaction scheduler with lock chaining and watchdog
module rr_port_scheduler #(
  parameter int NREQ  = 8,
  parameter int TMO   = 255,
  parameter int TMO_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  rr_port_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    LOCKWAIT = 2'd2
  } state_t;

  // Last watchdog count before expiry; the tmo pulse lands TMO cycles after start.
  localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'((TMO == 0) ? 0 : TMO - 1);

  state_t            r_state;
  logic [2:0]        r_ptr;
  logic [TMO_W-1:0]  r_wdog;
  logic [NREQ-1:0]   r_gnt;
  logic [3:0]        r_gnt_enc;
  logic              r_gnt_vld;
  logic              r_start;
  logic              r_tmo;
  logic [3:0]        r_tmo_id;
  logic              r_busy;

  logic [7:0]        w_req_ext;
  logic [7:0]        w_lock_ext;
  logic [2:0]        w_win;
  logic              w_any;
  logic [2:0]        w_own;
  logic [2:0]        w_ptr_nxt;
  logic              w_tmo_hit;

  // Wrap an index in [0, 2*NREQ) back into [0, NREQ).
  function automatic logic [2:0] f_wrap(input int a);
    int s;
    s = a;
    if (s >= NREQ) s = s - NREQ;
    return s[2:0];
  endfunction

  // Absent requesters (index >= NREQ) never request or lock.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ext
    if (gi < NREQ) begin : g_real
      assign w_req_ext[gi]  = bus.req[gi];
      assign w_lock_ext[gi] = bus.lock[gi];
    end else begin : g_tie
      assign w_req_ext[gi]  = 1'b0;
      assign w_lock_ext[gi] = 1'b0;
    end
  end

  assign w_own     = r_gnt_enc[2:0];
  assign w_ptr_nxt = f_wrap(int'(w_own) + 1);
  assign w_tmo_hit = (TMO != 0) && (r_wdog == LP_TMO_LAST);

  // First requester found scanning upward from the round-robin pointer.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && w_req_ext[f_wrap(int'(r_ptr) + i)]) begin
        w_win = f_wrap(int'(r_ptr) + i);
        w_any = 1'b1;
      end
    end
  end

  // Grant FSM with registered outputs; a grant ends by done, lock-chain release or watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_wdog    <= '0;
      r_gnt     <= '0;
      r_gnt_enc <= '0;
      r_gnt_vld <= 1'b0;
      r_start   <= 1'b0;
      r_tmo     <= 1'b0;
      r_tmo_id  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_tmo   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ce && bus.rdy && w_any) begin
            r_state   <= BUSY;
            r_gnt     <= NREQ'(1) << w_win;
            r_gnt_enc <= {1'b0, w_win};
            r_gnt_vld <= 1'b1;
            r_start   <= 1'b1;
            r_wdog    <= '0;
            r_busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.done) begin
            if (w_lock_ext[w_own] && w_req_ext[w_own]) begin
              r_state <= LOCKWAIT;
            end else begin
              r_state   <= IDLE;
              r_gnt     <= '0;
              r_gnt_enc <= '0;
              r_gnt_vld <= 1'b0;
              r_busy    <= 1'b0;
              r_ptr     <= w_ptr_nxt;
            end
          end else if (w_tmo_hit) begin
            r_tmo     <= 1'b1;
            r_tmo_id  <= r_gnt_enc;
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_enc <= '0;
            r_gnt_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= w_ptr_nxt;
          end else begin
            r_wdog <= r_wdog + TMO_W'(1);
          end
        end
        LOCKWAIT: begin
          if (!w_req_ext[w_own]) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_enc <= '0;
            r_gnt_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= w_ptr_nxt;
          end else if (bus.ce && bus.rdy) begin
            r_state <= BUSY;
            r_start <= 1'b1;
            r_wdog  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_enc = r_gnt_enc;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.start   = r_start;
  assign bus.tmo     = r_tmo;
  assign bus.tmo_id  = r_tmo_id;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_rr_port_scheduler.sv
// tb/tb_rr_port_scheduler.sv - self-checking bench for rr_port_scheduler
module tb_rr_port_scheduler;
  localparam int NREQ = 8;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_port_scheduler_if #(.NREQ(NREQ)) bus ();

  rr_port_scheduler #(.NREQ(NREQ), .TMO(TMO), .TMO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: who owns the resource and whether a transaction is open.
  int m_owner;
  int m_ptr;
  int m_age;
  int m_tmo_id;
  bit m_inflight;
  bit m_start;
  bit m_tmo;

  int since;
  int grants[$];
  int vld_low;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_age = 0; m_tmo_id = 0;
    m_inflight = 0; m_start = 0; m_tmo = 0;
  endtask

  function automatic int pick(input logic [7:0] r);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic m_release();
    m_ptr = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_inflight = 0;
  endtask

  task automatic model_step(input logic ce, input logic [7:0] req, input logic [7:0] lock,
                            input logic rdy, input logic done);
    m_start = 0;
    m_tmo = 0;
    if (m_owner < 0) begin
      if (ce && rdy && pick(req) >= 0) begin
        m_owner = pick(req); m_inflight = 1; m_age = 0; m_start = 1;
      end
    end else if (m_inflight) begin
      if (done) begin
        if (lock[m_owner] && req[m_owner]) m_inflight = 0;
        else m_release();
      end else if (m_age + 1 == TMO) begin
        m_tmo = 1; m_tmo_id = m_owner; m_release();
      end else begin
        m_age++;
      end
    end else begin
      if (!req[m_owner]) m_release();
      else if (ce && rdy) begin
        m_inflight = 1; m_age = 0; m_start = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    check_val("gnt", bus.gnt, eg);
    check_val("gnt_vld", bus.gnt_vld, m_owner >= 0);
    check_val("busy", bus.busy, m_owner >= 0);
    check_val("start", bus.start, m_start);
    check_val("tmo", bus.tmo, m_tmo);
    check_val("tmo_id", bus.tmo_id, m_tmo_id);
    if (m_owner >= 0) check_val("gnt_enc", bus.gnt_enc, m_owner);
  endtask

  task automatic cycle(input logic ce, input logic [7:0] req, input logic [7:0] lock,
                       input logic rdy, input logic done);
    bus.ce = ce; bus.req = req; bus.lock = lock; bus.rdy = rdy; bus.done = done;
    model_step(ce, req, lock, rdy, done);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ce = 0; bus.req = 0; bus.lock = 0; bus.rdy = 0; bus.done = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    since = 99;
    check_outputs();
  endtask

  // Fixed req/lock, done two cycles after each start; records granted owners.
  task automatic run_phase(input logic [7:0] req, input logic [7:0] lock, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (bus.start) begin
        grants.push_back(int'(bus.gnt_enc));
        since = 0;
      end else begin
        since++;
      end
      cycle(1'b1, req, lock, 1'b1, since == 2);
      if (!bus.gnt_vld) vld_low++;
    end
  endtask

  initial begin
    int n;
    int first;
    bus.ce = 0; bus.req = 0; bus.lock = 0; bus.rdy = 0; bus.done = 0;
    m_reset();
    since = 99;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_val("reset_gnt", bus.gnt, 0);
    check_val("reset_busy", bus.busy, 0);
    check_outputs();

    // Gating by rdy and ce, then release while ce is low.
    repeat (3) cycle(1, 8'h01, 0, 0, 0);
    check_val("gate_rdy_busy", bus.busy, 0);
    repeat (3) cycle(0, 8'h01, 0, 1, 0);
    check_val("gate_ce_busy", bus.busy, 0);
    cycle(1, 8'h01, 0, 1, 0);
    check_val("gate_grant", bus.gnt, 8'h01);
    cycle(0, 8'h01, 0, 1, 0);
    cycle(0, 8'h01, 0, 1, 1);
    check_val("ce_low_release", bus.gnt_vld, 0);

    // Full rotation with all requesters active.
    first = m_ptr;
    grants.delete();
    run_phase(8'hFF, 8'h00, 40);
    check_val("rot_count", grants.size() >= 9, 1);
    foreach (grants[k]) check_val("rot_enc", grants[k], (first + k) % NREQ);

    // Fairness: after owner 5, pointer 6 wraps to 0 before 5 again.
    do_reset();
    run_phase(8'h20, 8'h00, 4);
    grants.delete();
    run_phase(8'h21, 8'h00, 12);
    check_val("fair_first", grants.size() > 0 ? grants[0] : -1, 0);
    check_val("fair_second", grants.size() > 1 ? grants[1] : -1, 5);

    // Lock chain on owner 3, then release lock.
    do_reset();
    run_phase(8'h04, 8'h00, 4);
    grants.delete();
    vld_low = 0;
    run_phase(8'h0C, 8'h08, 20);
    check_val("lock_starts", grants.size() >= 3, 1);
    foreach (grants[k]) check_val("lock_owner", grants[k], 3);
    check_val("lock_gnt_held", vld_low, 0);
    grants.delete();
    run_phase(8'h0C, 8'h00, 12);
    check_val("unlock_last_start", grants.size() > 0 ? grants[0] : -1, 3);
    check_val("unlock_next", grants.size() > 1 ? grants[1] : -1, 2);

    // Watchdog expiry and done-wins-over-timeout.
    do_reset();
    cycle(1, 8'h06, 0, 1, 0);
    check_val("wd_grant", bus.gnt, 8'h02);
    n = 0;
    while (!bus.tmo && n < 10) begin
      cycle(1, 8'h06, 0, 1, 0);
      n++;
    end
    check_val("wd_latency", n, TMO);
    check_val("wd_tmo_id", bus.tmo_id, 1);
    check_val("wd_gnt_clear", bus.gnt, 0);
    cycle(1, 8'h06, 0, 1, 0);
    check_val("wd_next_owner", bus.gnt, 8'h04);
    repeat (TMO - 1) cycle(1, 8'h06, 0, 1, 0);
    cycle(1, 8'h06, 0, 1, 1);
    check_val("wd_done_wins_tmo", bus.tmo, 0);
    check_val("wd_done_wins_gnt", bus.gnt_vld, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 4) != 0, 8'($urandom & $urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of a transaction.
    do_reset();
    cycle(1, 8'h04, 0, 1, 0);
    check_val("rst_pre_gnt", bus.gnt, 8'h04);
    cycle(1, 8'h04, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    check_val("async_gnt", bus.gnt, 0);
    check_val("async_vld", bus.gnt_vld, 0);
    check_val("async_busy", bus.busy, 0);
    check_val("async_enc", bus.gnt_enc, 0);
    check_val("async_tmo", bus.tmo, 0);
    do_reset();
    cycle(1, 8'h04, 0, 1, 0);
    check_val("post_rst_gnt", bus.gnt, 8'h04);
    check_val("post_rst_enc", bus.gnt_enc, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rr_port_scheduler.md
# rr_port_scheduler

Transaction-level round-robin scheduler that shares one single-ported resource, such as a memory or cache port, among up to eight requesters. It grants one owner at a time and keeps the grant until the resource signals completion. A lock lets an owner chain back-to-back transactions, and a watchdog revokes any grant that hangs. It sits between the requesting units and the resource's command interface, and supplies the one-hot and encoded select used to steer that resource's input mux.

## Interface
- NREQ, 8, number of requesters (2..8)
- TMO, 255, watchdog limit in cycles after `start`; 0 disables the watchdog
- TMO_W, 8, watchdog counter width; must hold TMO
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ce  in  1  clock enable; gates new grants only
- req  in  NREQ  per-requester transaction request, level
- lock  in  NREQ  per-requester chain request; meaningful only for the current owner
- rdy  in  1  resource can accept a new transaction
- done  in  1  resource completed the current transaction (1-cycle pulse)
- gnt  out  NREQ  one-hot owner select, registered
- gnt_enc  out  4  encoded owner; valid when gnt_vld
- gnt_vld  out  1  an owner is granted
- start  out  1  1-cycle pulse: resource begins a transaction for the owner
- tmo  out  1  1-cycle pulse: watchdog revoked the grant
- tmo_id  out  4  owner that timed out; holds until the next tmo
- busy  out  1  FSM is not in IDLE

## Operation
- **States:** IDLE, BUSY, LOCKWAIT.
- **Round-robin pointer `ptr`** (3 bits):
  - Priority is req[ptr], then req[ptr+1], and so on, wrapping modulo NREQ.
  - After any grant ends (done without lock, lock release, or timeout), ptr = owner+1 mod NREQ.
- **IDLE:**
  - gnt=0, gnt_vld=0.
  - If ce & rdy & |req[NREQ-1:0], latch the winner into gnt/gnt_enc, assert gnt_vld, pulse start, clear the watchdog, and go to BUSY.
- **BUSY:**
  - The owner is held regardless of req/lock changes.
  - Watchdog increments each cycle.
  - On done: if lock[owner] & req[owner], go to LOCKWAIT with gnt held. Otherwise clear gnt/gnt_vld, advance ptr, and go to IDLE.
  - If TMO≠0 and the watchdog reaches TMO without done: pulse tmo, set tmo_id=owner, clear gnt, advance ptr, go to IDLE. The owner's lock is ignored.
  - done and timeout in the same cycle: done wins, no tmo.
- **LOCKWAIT:**
  - gnt held.
  - If req[owner] drops, clear gnt, advance ptr, go to IDLE.
  - Else if ce & rdy, pulse start, clear the watchdog, go to BUSY.
  - Dropping lock with req still high in LOCKWAIT still issues the next start; lock is only checked at done.
- **ce=0:** IDLE and LOCKWAIT hold. BUSY completion and timeout are still processed.
- **done outside BUSY:** ignored.
- **Requester indices ≥ NREQ:** absent; tied off internally.
- **Reset (rst_n low, any state):** state=IDLE, ptr=0, watchdog=0, gnt=0, gnt_enc=0, gnt_vld=0, start=0, tmo=0, tmo_id=0, busy=0. A transaction in flight is abandoned without tmo.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- **Grant latency:** req/rdy sampled in IDLE at edge N; gnt, gnt_vld and start are high in cycle N+1.
- **start width:** exactly one cycle per transaction. gnt stays stable from start until release.
- **Release:** done at cycle M (unlocked) gives gnt=0 in M+1. The earliest next grant is visible in M+2.
- **Chained (locked) transaction:** done at M; LOCKWAIT in M+1 samples rdy; start in M+2. Best case is one issue every 2 cycles plus the resource's own latency.
- **Timeout:** start in cycle S with no done gives tmo=1 and gnt=0 in cycle S+TMO.
- **Minimum gnt_vld-low gap** between different owners: 1 cycle.

## Test plan
- **Reset:** assert rst_n=0 mid-BUSY (gnt=8'h04) -> all outputs 0 immediately. After release, req=8'h04 -> gnt=8'h04, gnt_enc=2.
- **Full rotation:** req=8'hFF, rdy=1, done 2 cycles after each start -> gnt_enc sequence 0,1,2,...,7,0, one start per grant, gnt_vld low 1 cycle between grants.
- **Fairness:** serve owner 5, then req=8'h21 -> next grant is 0 (ptr=6 wraps), then 5.
- **Lock chain:** req=8'h0C, lock[3]=1 after ptr=3, for three transactions -> three starts for gnt=8'h08 with gnt never dropping, then lock=0 -> gnt=8'h04 after one idle cycle.
- **Watchdog:** TMO=4; grant owner 1, never pulse done -> tmo=1, tmo_id=1, gnt=0 exactly 4 cycles after start. Pending req[2] is granted next. Repeat with done in the timeout cycle -> no tmo.
- **Gating:** req=8'h01 with rdy=0 or ce=0 -> no grant, busy=0. Raise both -> grant next cycle. Drop ce during BUSY, then pulse done -> release still occurs.
